// File: rtl/conf_pkg.sv
// Shared definitions for the configuration scheduler: word indices, FSM states, bank type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conf_pkg;

    localparam int CP_PAR_W = 8;
    localparam int CP_PAR_N = 5;

    // Position of each parameter inside the frame / bank
    localparam int IDX_PW   = 0;
    localparam int IDX_FREQ = 1;
    localparam int IDX_OCD  = 2;
    localparam int IDX_PRED = 3;
    localparam int IDX_GEN  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STAGED  = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_LOCKOUT = 2'd3
    } conf_state_t;

    typedef logic [CP_PAR_N-1:0][CP_PAR_W-1:0] par_bank_t;

endpackage

// File: rtl/conf_ramp.sv
// Pulse-width slew limiter: raises pw by one every RAMP_STEP_CLKS cycles toward the target.
// Latency: decreases pass through combinationally, increases step after RAMP_STEP_CLKS cycles.
// Backpressure: none; follows i_target every cycle, i_lock forces the ramp back to zero.
// Ports: clk/rst (sync, active-high), i_target committed pw, i_lock lockout active, o_pw limited pw.
module conf_ramp #(
    parameter int PAR_W          = 8,
    parameter int RAMP_STEP_CLKS = 50000
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [PAR_W-1:0] i_target,
    input  logic             i_lock,
    output logic [PAR_W-1:0] o_pw
);

    localparam int               STEP_W    = (RAMP_STEP_CLKS > 1) ? $clog2(RAMP_STEP_CLKS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEP_CLKS - 1);

    logic [PAR_W-1:0]  r_pw_cur;
    logic [STEP_W-1:0] r_step_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_lock) begin
            r_pw_cur   <= '0;
            r_step_cnt <= '0;
        end else if (i_target <= r_pw_cur) begin
            // at or above target: snap down and keep the step timer parked
            r_pw_cur   <= i_target;
            r_step_cnt <= '0;
        end else if (r_step_cnt == STEP_LAST) begin
            r_pw_cur   <= r_pw_cur + 1'b1;
            r_step_cnt <= '0;
        end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
        end
    end

    // A lowered target shows up in the same cycle it is committed
    assign o_pw = (i_target < r_pw_cur) ? i_target : r_pw_cur;

endmodule

// File: rtl/conf_sched.sv
// Configuration scheduler: stages clamped UART frames, commits the bank atomically while the
// interrupter is idle, and latches an over-current lockout on repeated OCD trips.
// Latency: in_vld at N -> pending at N+1 -> commit/out_par at N+2 at the earliest.
// Backpressure: int_busy defers the commit indefinitely; a newer frame overwrites the staged one.
// Ports: clk, rst (sync, active-high); in_par/in_vld frame input; int_busy interrupter on-time;
//        ocd_trip trip strobe; out_par committed bank; commit pulse; pending staged flag; fault lockout.
// Option: CONF_SCHED_RAMP_EN adds a pw slew limiter (conf_ramp) on out_par word 0.
module conf_sched
    import conf_pkg::*;
#(
    parameter int PAR_W          = CP_PAR_W,
    parameter int PAR_N          = CP_PAR_N,
    parameter int PW_MAX         = 255,
    parameter int OCD_MAX        = 200,
    parameter int FAULT_MAX      = 3,
    parameter int FAULT_WIN_CLKS = 1000000
`ifdef CONF_SCHED_RAMP_EN
    ,
    parameter int RAMP_STEP_CLKS = 50000
`endif
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PAR_N-1:0][PAR_W-1:0] in_par,
    input  logic                        in_vld,
    input  logic                        int_busy,
    input  logic                        ocd_trip,
    output logic [PAR_N-1:0][PAR_W-1:0] out_par,
    output logic                        commit,
    output logic                        pending,
    output logic                        fault
);

    localparam int                CNT_W      = $clog2(FAULT_MAX + 1);
    localparam int                TMR_W      = (FAULT_WIN_CLKS > 1) ? $clog2(FAULT_WIN_CLKS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOCK   = CNT_W'(FAULT_MAX);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(FAULT_WIN_CLKS - 1);
    localparam logic [PAR_W-1:0]  PW_CEIL    = PAR_W'(PW_MAX);
    localparam logic [PAR_W-1:0]  OCD_CEIL   = PAR_W'(OCD_MAX);
    localparam logic [PAR_W-1:0]  FREQ_FLOOR = PAR_W'(1);

    conf_state_t                 r_state;
    conf_state_t                 w_state_nxt;
    logic [PAR_N-1:0][PAR_W-1:0] r_stage;
    logic [PAR_N-1:0][PAR_W-1:0] r_out_par;
    logic [PAR_N-1:0][PAR_W-1:0] w_out_par;
    logic [CNT_W-1:0]            r_trip_cnt;
    logic [CNT_W-1:0]            w_cnt_nxt;
    logic [TMR_W-1:0]            r_timer;
    logic [TMR_W-1:0]            w_tmr_nxt;
    logic                        w_lock;
    logic [PAR_W-1:0]            w_pw_src;

    // Written as min/max selects so a ceiling equal to the full word range still synthesises away
    function automatic logic [PAR_N-1:0][PAR_W-1:0] clamp_frame(
        input logic [PAR_N-1:0][PAR_W-1:0] f
    );
        logic [PAR_N-1:0][PAR_W-1:0] c;
        c          = f;
        c[IDX_PW]   = (f[IDX_PW]   < PW_CEIL)    ? f[IDX_PW]   : PW_CEIL;
        c[IDX_OCD]  = (f[IDX_OCD]  < OCD_CEIL)   ? f[IDX_OCD]  : OCD_CEIL;
        c[IDX_FREQ] = (f[IDX_FREQ] < FREQ_FLOOR) ? FREQ_FLOOR  : f[IDX_FREQ];
        return c;
    endfunction

    // Trip window: the first trip arms the timer; the expiry cycle clears the count unless a
    // trip lands in it, in which case that trip opens a fresh window.
    always_comb begin
        w_cnt_nxt = r_trip_cnt;
        w_tmr_nxt = r_timer;
        if (r_trip_cnt == '0) begin
            if (ocd_trip) begin
                w_cnt_nxt = CNT_ONE;
                w_tmr_nxt = TMR_LOAD;
            end
        end else if (r_timer == '0) begin
            if (ocd_trip) begin
                w_cnt_nxt = CNT_ONE;
                w_tmr_nxt = TMR_LOAD;
            end else begin
                w_cnt_nxt = '0;
            end
        end else begin
            w_tmr_nxt = r_timer - 1'b1;
            if (ocd_trip) begin
                w_cnt_nxt = r_trip_cnt + 1'b1;
            end
        end
        w_lock = (w_cnt_nxt >= CNT_LOCK);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_vld) w_state_nxt = ST_STAGED;
            end
            ST_STAGED: begin
                // a frame arriving now replaces the staged one and restarts the wait
                if (in_vld)         w_state_nxt = ST_STAGED;
                else if (!int_busy) w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_state_nxt = in_vld ? ST_STAGED : ST_IDLE;
            end
            ST_LOCKOUT: begin
                w_state_nxt = ST_LOCKOUT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_lock) w_state_nxt = ST_LOCKOUT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_stage    <= '0;
            r_out_par  <= '0;
            r_trip_cnt <= '0;
            r_timer    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (in_vld) begin
                r_stage <= clamp_frame(in_par);
            end
            // out_par changes on entry to COMMIT so it lines up with the commit pulse
            if (w_state_nxt == ST_COMMIT && r_state != ST_COMMIT) begin
                r_out_par <= r_stage;
            end
            if (r_state != ST_LOCKOUT) begin
                r_trip_cnt <= w_cnt_nxt;
                r_timer    <= w_tmr_nxt;
            end
        end
    end

`ifdef CONF_SCHED_RAMP_EN
    conf_ramp #(
        .PAR_W          (PAR_W),
        .RAMP_STEP_CLKS (RAMP_STEP_CLKS)
    ) u_ramp (
        .clk      (clk),
        .rst      (rst),
        .i_target (r_out_par[IDX_PW]),
        .i_lock   (r_state == ST_LOCKOUT),
        .o_pw     (w_pw_src)
    );
`else
    assign w_pw_src = r_out_par[IDX_PW];
`endif

    always_comb begin
        w_out_par         = r_out_par;
        w_out_par[IDX_PW] = w_pw_src;
        if (r_state == ST_LOCKOUT) begin
            w_out_par[IDX_PW] = '0;
        end
    end

    assign out_par = w_out_par;
    assign commit  = (r_state == ST_COMMIT);
    assign pending = (r_state == ST_STAGED);
    assign fault   = (r_state == ST_LOCKOUT);

endmodule

// File: tb/tb_conf_sched.sv
// Bench for conf_sched: directed scenarios plus a randomized run against a cycle-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_conf_sched;
    import conf_pkg::*;

    localparam int PW_MAX  = 255;
    localparam int OCD_MAX = 200;
    localparam int FMAX    = 3;
    localparam int WIN     = 64;
`ifdef CONF_SCHED_RAMP_EN
    localparam logic [39:0] OUT_MASK = {32'hFFFF_FFFF, 8'h00};
`else
    localparam logic [39:0] OUT_MASK = '1;
`endif

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    par_bank_t in_par = '0;
    logic      in_vld = 1'b0;
    logic      int_busy = 1'b0;
    logic      ocd_trip = 1'b0;
    par_bank_t out_par;
    logic      commit;
    logic      pending;
    logic      fault;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int        cyc = 0;
    logic      m_pending, m_commit, m_fault;
    par_bank_t m_stage, m_out;
    int        m_cnt, m_ws;

    conf_sched #(
        .PAR_W          (8),
        .PAR_N          (5),
        .PW_MAX         (PW_MAX),
        .OCD_MAX        (OCD_MAX),
        .FAULT_MAX      (FMAX),
        .FAULT_WIN_CLKS (WIN)
`ifdef CONF_SCHED_RAMP_EN
        ,
        .RAMP_STEP_CLKS (4)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_par   (in_par),
        .in_vld   (in_vld),
        .int_busy (int_busy),
        .ocd_trip (ocd_trip),
        .out_par  (out_par),
        .commit   (commit),
        .pending  (pending),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    function automatic par_bank_t clamp_ref(par_bank_t f);
        par_bank_t r;
        r = f;
        if (int'(f[0]) > PW_MAX)  r[0] = 8'(PW_MAX);
        if (int'(f[2]) > OCD_MAX) r[2] = 8'(OCD_MAX);
        if (int'(f[1]) < 1)       r[1] = 8'd1;
        return r;
    endfunction

    function automatic par_bank_t exp_out();
        par_bank_t r;
        r = m_out;
        if (m_fault) r[0] = 8'd0;
        return r;
    endfunction

    // One clock edge with the currently driven inputs; the model advances alongside.
    task automatic tick();
        logic v, b, tr, lock_n;
        par_bank_t p;
        v = in_vld; b = int_busy; tr = ocd_trip; p = in_par;
        lock_n = m_fault;
        if (!m_fault && tr) begin
            if (m_cnt == 0 || cyc >= m_ws + WIN) begin
                m_cnt = 1;
                m_ws  = cyc;
            end else begin
                m_cnt++;
            end
            if (m_cnt >= FMAX) lock_n = 1'b1;
        end
        if (lock_n) begin
            m_commit  = 1'b0;
            m_pending = 1'b0;
        end else begin
            m_commit  = m_pending && !b && !v;
            m_pending = v || (m_pending && b);
            if (m_commit) m_out = m_stage;
        end
        if (v) m_stage = clamp_ref(p);
        m_fault = lock_n;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_vld = 1'b0; int_busy = 1'b0; ocd_trip = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        m_pending = 0; m_commit = 0; m_fault = 0;
        m_stage = '0; m_out = '0; m_cnt = 0; m_ws = 0;
    endtask

    task automatic test_reset();
        in_par = {$urandom, 8'hA5};
        in_vld = 1'b1; ocd_trip = 1'b1; int_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        n_tests++; if (out_par !== '0) begin n_fail++; $display("FAIL reset_out got=%h exp=0", out_par); end
        n_tests++; if (commit !== 1'b0) begin n_fail++; $display("FAIL reset_commit got=%b exp=0", commit); end
        n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0", pending); end
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", fault); end
    endtask

    task automatic test_basic();
        par_bank_t want;
        want = {8'd127, 8'd30, 8'd200, 8'd1, 8'd100};
        do_reset();
        in_par = {8'd127, 8'd30, 8'd250, 8'd0, 8'd100};
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        n_tests++; if (pending !== 1'b1 || commit !== 1'b0) begin
            n_fail++; $display("FAIL basic_staged pending=%b commit=%b exp 1/0", pending, commit); end
        tick();
        n_tests++; if (commit !== 1'b1 || pending !== 1'b0) begin
            n_fail++; $display("FAIL basic_commit commit=%b pending=%b exp 1/0", commit, pending); end
        n_tests++; if ((out_par & OUT_MASK) !== (want & OUT_MASK)) begin
            n_fail++; $display("FAIL basic_out got=%h exp=%h", out_par & OUT_MASK, want & OUT_MASK); end
        tick();
        n_tests++; if (commit !== 1'b0) begin n_fail++; $display("FAIL basic_pulse got=%b exp=0", commit); end
    endtask

    task automatic test_busy_defer();
        int bad;
        bad = 0;
        int_busy = 1'b1;
        in_par = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5};
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (pending !== 1'b1 || commit !== 1'b0 || (out_par & OUT_MASK) !== (exp_out() & OUT_MASK)) bad++;
            tick();
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL busy_hold bad_cycles=%0d exp=0", bad); end
        int_busy = 1'b0;
        tick();
        n_tests++; if (commit !== 1'b1) begin n_fail++; $display("FAIL busy_release commit=%b exp=1", commit); end
        n_tests++; if (out_par[4:1] !== {8'd9, 8'd8, 8'd7, 8'd6}) begin
            n_fail++; $display("FAIL busy_out got=%h exp=09080706", out_par[4:1]); end
        tick();
    endtask

    task automatic test_newest_wins();
        int commits;
        commits = 0;
        int_busy = 1'b1;
        in_par = {8'd1, 8'd2, 8'd3, 8'd4, 8'd50};
        in_vld = 1'b1;
        tick();
        in_par = {8'd11, 8'd12, 8'd13, 8'd14, 8'd80};
        tick();
        in_vld = 1'b0;
        int_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (commit === 1'b1) commits++;
        end
        n_tests++; if (commits != 1) begin n_fail++; $display("FAIL newest_commits got=%0d exp=1", commits); end
        n_tests++; if (m_out[0] !== 8'd80 || (out_par & OUT_MASK) !== ({8'd11, 8'd12, 8'd13, 8'd14, 8'd80} & OUT_MASK)) begin
            n_fail++; $display("FAIL newest_out got=%h exp=0b0c0d0e50", out_par); end
    endtask

    task automatic test_fault();
        int commits;
        commits = 0;
        do_reset();
        in_par = {8'd40, 8'd41, 8'd42, 8'd43, 8'd100};
        in_vld = 1'b1; tick(); in_vld = 1'b0;
        repeat (3) tick();
        ocd_trip = 1'b1; tick(); ocd_trip = 1'b0;
        repeat (10) tick();
        ocd_trip = 1'b1; tick(); ocd_trip = 1'b0;
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_early got=%b exp=0", fault); end
        repeat (10) tick();
        ocd_trip = 1'b1; tick(); ocd_trip = 1'b0;
        n_tests++; if (fault !== 1'b1 || out_par[0] !== 8'd0) begin
            n_fail++; $display("FAIL fault_lock fault=%b pw=%0d exp 1/0", fault, out_par[0]); end
        n_tests++; if (out_par[4:1] !== {8'd40, 8'd41, 8'd42, 8'd43}) begin
            n_fail++; $display("FAIL fault_hold got=%h exp=28292a2b", out_par[4:1]); end
        in_par = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        in_vld = 1'b1; tick(); in_vld = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (commit === 1'b1) commits++;
        end
        n_tests++; if (commits != 0 || fault !== 1'b1) begin
            n_fail++; $display("FAIL fault_nocommit commits=%0d fault=%b exp 0/1", commits, fault); end
        do_reset();
        n_tests++; if (fault !== 1'b0 || out_par !== '0) begin
            n_fail++; $display("FAIL fault_rst fault=%b out=%h exp 0/0", fault, out_par); end
    endtask

    task automatic trips_at_gap(int gap);
        ocd_trip = 1'b1; tick(); ocd_trip = 1'b0;
        ocd_trip = 1'b1; tick(); ocd_trip = 1'b0;
        repeat (gap) tick();
        ocd_trip = 1'b1; tick(); ocd_trip = 1'b0;
    endtask

    task automatic test_window();
        // 2 trips then the third well after the window closes
        do_reset();
        trips_at_gap(WIN + 2);
        repeat (3) tick();
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL win_late got=%b exp=0", fault); end
        // third trip in the last cycle of the window still counts
        do_reset();
        trips_at_gap(WIN - 3);
        n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL win_last got=%b exp=1", fault); end
        // third trip in the expiry cycle opens a new window instead
        do_reset();
        trips_at_gap(WIN - 2);
        tick();
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL win_expiry got=%b exp=0", fault); end
        ocd_trip = 1'b1; tick(); ocd_trip = 1'b0;
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL win_new2 got=%b exp=0", fault); end
        ocd_trip = 1'b1; tick(); ocd_trip = 1'b0;
        n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL win_new3 got=%b exp=1", fault); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_par = {8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        in_vld = 1'b1; tick(); in_vld = 1'b0;
        tick(); tick();
        int_busy = 1'b1;
        in_vld = 1'b1; tick(); in_vld = 1'b0;
        do_reset();
        repeat (3) tick();
        n_tests++; if (pending !== 1'b0 || commit !== 1'b0 || out_par !== '0) begin
            n_fail++; $display("FAIL rstmid pending=%b commit=%b out=%h exp 0/0/0", pending, commit, out_par); end
    endtask

    task automatic test_random();
        int bad_c, bad_p, bad_f, bad_o;
        bad_c = 0; bad_p = 0; bad_f = 0; bad_o = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            in_vld = ($urandom_range(0, 5) == 0);
            for (int w = 0; w < 5; w++) begin
                case ($urandom_range(0, 3))
                    0:       in_par[w] = 8'd0;
                    1:       in_par[w] = 8'hFF;
                    default: in_par[w] = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 7) == 0) int_busy = ~int_busy;
            ocd_trip = ($urandom_range(0, 59) == 0);
            tick();
            n_tests++;
            if (commit !== m_commit) begin bad_c++; n_fail++;
                if (bad_c < 4) $display("FAIL rand_commit cyc=%0d got=%b exp=%b", cyc, commit, m_commit); end
            n_tests++;
            if (pending !== m_pending) begin bad_p++; n_fail++;
                if (bad_p < 4) $display("FAIL rand_pending cyc=%0d got=%b exp=%b", cyc, pending, m_pending); end
            n_tests++;
            if (fault !== m_fault) begin bad_f++; n_fail++;
                if (bad_f < 4) $display("FAIL rand_fault cyc=%0d got=%b exp=%b", cyc, fault, m_fault); end
            n_tests++;
            if ((out_par & OUT_MASK) !== (exp_out() & OUT_MASK)) begin bad_o++; n_fail++;
                if (bad_o < 4) $display("FAIL rand_out cyc=%0d got=%h exp=%h", cyc, out_par & OUT_MASK, exp_out() & OUT_MASK); end
            if (m_fault && $urandom_range(0, 24) == 0) do_reset();
        end
        in_vld = 1'b0; int_busy = 1'b0; ocd_trip = 1'b0;
    endtask

`ifdef CONF_SCHED_RAMP_EN
    task automatic test_ramp();
        do_reset();
        in_par = {8'd0, 8'd0, 8'd0, 8'd1, 8'd3};
        in_vld = 1'b1; tick(); in_vld = 1'b0;
        tick();
        n_tests++; if (commit !== 1'b1 || out_par[0] !== 8'd0) begin
            n_fail++; $display("FAIL ramp_start commit=%b pw=%0d exp 1/0", commit, out_par[0]); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3 || k == 4 || k == 8 || k == 12) begin
                n_tests++;
                if (int'(out_par[0]) != (k / 4)) begin
                    n_fail++; $display("FAIL ramp_step k=%0d got=%0d exp=%0d", k, out_par[0], k / 4); end
            end
        end
        in_par = {8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
        in_vld = 1'b1; tick(); in_vld = 1'b0;
        tick();
        n_tests++; if (commit !== 1'b1 || out_par[0] !== 8'd1) begin
            n_fail++; $display("FAIL ramp_down commit=%b pw=%0d exp 1/1", commit, out_par[0]); end
    endtask
`endif

    initial begin
        m_pending = 0; m_commit = 0; m_fault = 0;
        m_stage = '0; m_out = '0; m_cnt = 0; m_ws = 0;
        test_reset();
        test_basic();
        test_busy_defer();
        test_newest_wins();
        test_fault();
        test_window();
        test_reset_mid();
        test_random();
`ifdef CONF_SCHED_RAMP_EN
        test_ramp();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
